// File: rtl/ospfb_pkg.sv
// Shared types and sizing helpers for the FFT frame capture block.
package ospfb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    function automatic int idx_width(input int fft_len);
        return (fft_len > 1) ? $clog2(fft_len) : 1;
    endfunction

    function automatic int addr_width(input int fft_len, input int nframes);
        return (fft_len * nframes > 1) ? $clog2(fft_len * nframes) : 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sdp_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Non-blocking read of the array gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_frame_capture.sv
// Captures NFRAMES frame-aligned FFT output frames into a readable buffer,
// flagging tlast and bin-index protocol errors.
module fft_frame_capture
    import ospfb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FFT_LEN   = 64,
    parameter int NFRAMES   = 4,
    parameter int TUSER_WID = 8
) (
    input  logic                                  clk,
    input  logic                                  aresetn,
    input  logic [2*WIDTH-1:0]                    s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    input  logic [TUSER_WID-1:0]                  s_axis_tuser,
    input  logic                                  arm,
    input  logic [$clog2(FFT_LEN*NFRAMES)-1:0]    rd_addr,
    output logic [2*WIDTH-1:0]                    rd_data,
    output logic                                  full,
    output logic                                  busy,
    output logic [$clog2(NFRAMES+1)-1:0]          frame_count,
    output logic                                  err_tlast_early,
    output logic                                  err_tlast_missing,
    output logic                                  err_tuser
);

    localparam int IW    = idx_width(FFT_LEN);
    localparam int AW    = addr_width(FFT_LEN, NFRAMES);
    localparam int FCW   = $clog2(NFRAMES + 1);
    localparam int DEPTH = FFT_LEN * NFRAMES;

    cap_state_t       state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [FCW-1:0]   fcnt, fcnt_nxt, fcnt_inc;
    logic             e_early, e_early_nxt;
    logic             e_miss, e_miss_nxt;
    logic             e_user, e_user_nxt;
    logic             beat, we, last_slot;
    logic [AW-1:0]    wr_addr;
    logic [TUSER_WID-1:0] exp_user;

    assign beat      = s_axis_tvalid && s_axis_tready;
    assign last_slot = (idx == IW'(FFT_LEN - 1));
    assign exp_user  = TUSER_WID'(idx);
    assign fcnt_inc  = fcnt + FCW'(1);
    assign wr_addr   = AW'(fcnt) * AW'(FFT_LEN) + AW'(idx);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            idx     <= '0;
            fcnt    <= '0;
            e_early <= 1'b0;
            e_miss  <= 1'b0;
            e_user  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            fcnt    <= fcnt_nxt;
            e_early <= e_early_nxt;
            e_miss  <= e_miss_nxt;
            e_user  <= e_user_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        fcnt_nxt      = fcnt;
        e_early_nxt   = e_early;
        e_miss_nxt    = e_miss;
        e_user_nxt    = e_user;
        we            = 1'b0;
        s_axis_tready = (state != DONE);
        case (state)
            IDLE, DONE: begin
                if (arm) begin
                    state_nxt   = SYNC;
                    idx_nxt     = '0;
                    fcnt_nxt    = '0;
                    e_early_nxt = 1'b0;
                    e_miss_nxt  = 1'b0;
                    e_user_nxt  = 1'b0;
                end
            end
            SYNC: begin
                // The tlast beat only marks the boundary; it belongs to a partial frame.
                if (beat && s_axis_tlast) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (beat) begin
                    we = 1'b1;
                    if (s_axis_tuser != exp_user)      e_user_nxt  = 1'b1;
                    if (s_axis_tlast && !last_slot)    e_early_nxt = 1'b1;
                    if (!s_axis_tlast && last_slot)    e_miss_nxt  = 1'b1;
                    if (s_axis_tlast || last_slot) begin
                        idx_nxt  = '0;
                        fcnt_nxt = fcnt_inc;
                        if (fcnt_inc == FCW'(NFRAMES)) state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign full              = (state == DONE);
    assign busy              = (state == SYNC) || (state == CAPTURE);
    assign frame_count       = fcnt;
    assign err_tlast_early   = e_early;
    assign err_tlast_missing = e_miss;
    assign err_tuser         = e_user;

    sdp_ram #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_addr),
        .wdata (s_axis_tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fft_frame_capture.sv
// Randomized scenario bench for fft_frame_capture with a frame-level reference model.
module tb_fft_frame_capture;

    localparam int W = 16, L = 64, NF = 4, TW = 8;
    localparam int DEPTH = L * NF;
    localparam int AW = $clog2(DEPTH);
    localparam int FCW = $clog2(NF + 1);
    localparam int M_IDLE = 0, M_SYNC = 1, M_CAP = 2, M_DONE = 3;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic [2*W-1:0]  s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            s_axis_tlast = 1'b0;
    logic [TW-1:0]   s_axis_tuser = '0;
    logic            arm = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [2*W-1:0]  rd_data;
    logic            full, busy;
    logic [FCW-1:0]  frame_count;
    logic            err_tlast_early, err_tlast_missing, err_tuser;

    fft_frame_capture #(.WIDTH(W), .FFT_LEN(L), .NFRAMES(NF), .TUSER_WID(TW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .arm(arm),
        .rd_addr(rd_addr), .rd_data(rd_data), .full(full), .busy(busy), .frame_count(frame_count),
        .err_tlast_early(err_tlast_early), .err_tlast_missing(err_tlast_missing), .err_tuser(err_tuser)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Reference model: capture mode, write pointer within frame, frames done, sticky flags.
    int m_mode, m_idx, m_frame;
    bit m_early, m_miss, m_user;
    logic [2*W-1:0] mm [DEPTH];
    bit             mk [DEPTH];
    logic [2*W-1:0] frame_data [L];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_frame = 0;
        m_early = 0; m_miss = 0; m_user = 0;
    endtask

    task automatic model_beat(input logic [2*W-1:0] d, input int u, input bit last);
        if (m_mode == M_SYNC) begin
            if (last) m_mode = M_CAP;
        end else if (m_mode == M_CAP) begin
            mm[m_frame*L + m_idx] = d;
            mk[m_frame*L + m_idx] = 1'b1;
            if ((u % 256) != (m_idx % 256)) m_user = 1;
            if (last && m_idx < L-1) m_early = 1;
            if (!last && m_idx == L-1) m_miss = 1;
            if (last || m_idx == L-1) begin
                m_idx = 0;
                m_frame++;
                if (m_frame == NF) m_mode = M_DONE;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic do_arm();
        arm = 1'b1; s_axis_tvalid = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            m_mode = M_SYNC; m_idx = 0; m_frame = 0;
            m_early = 0; m_miss = 0; m_user = 0;
        end
        tick();
        arm = 1'b0;
    endtask

    task automatic send_beat(input int bin, input int user, input bit last);
        logic [2*W-1:0] d;
        if ($urandom_range(0, 3) == 0) tick();
        d = $urandom;
        frame_data[bin] = d;
        s_axis_tdata = d; s_axis_tuser = TW'(user); s_axis_tlast = last; s_axis_tvalid = 1'b1;
        if (m_mode != M_DONE) model_beat(d, user, last);
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    // Bins first..last_bin with tuser=bin except at bad_idx; tlast only at tlast_bin.
    task automatic send_frame(input int first, input int last_bin, input int tlast_bin,
                              input int bad_idx, input int bad_user);
        for (int b = first; b <= last_bin; b++)
            send_beat(b, (b == bad_idx) ? bad_user : b, b == tlast_bin);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; model_reset();
        tick(); tick();
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b exp 1", s_axis_tready); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_count !== '0) begin errors++; $display("FAIL reset_fcnt got %0d exp 0", frame_count); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_tuser} !== 3'b000) begin
            errors++; $display("FAIL reset_errs got %b exp 000", {err_tlast_early, err_tlast_missing, err_tuser}); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_clean();
        logic [2*W-1:0] f1b6;
        do_arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_sync got %b exp 1", busy); end
        send_frame(0, 63, 63, -1, 0);
        checks++; if (frame_count !== '0) begin errors++; $display("FAIL clean_sync_discard got %0d exp 0", frame_count); end
        for (int f = 0; f < 3; f++) begin
            send_frame(0, 63, 63, -1, 0);
            if (f == 1) f1b6 = frame_data[6];
        end
        send_frame(0, 62, 63, -1, 0);
        checks++; if (full !== 1'b0 || frame_count !== 3'd3) begin
            errors++; $display("FAIL clean_prefinal got full=%b fc=%0d exp full=0 fc=3", full, frame_count); end
        send_beat(63, 63, 1'b1);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL clean_full got %b exp 1", full); end
        checks++; if (frame_count !== 3'd4) begin errors++; $display("FAIL clean_fcnt got %0d exp 4", frame_count); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_tuser} !== 3'b000) begin
            errors++; $display("FAIL clean_errs got %b exp 000", {err_tlast_early, err_tlast_missing, err_tuser}); end
        checks++; if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL clean_done got busy=%b tready=%b exp 0 0", busy, s_axis_tready); end
        rd_addr = AW'(70); tick();
        checks++; if (rd_data !== f1b6) begin errors++; $display("FAIL clean_rd70 got %h exp %h", rd_data, f1b6); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a); tick();
            if (mk[a]) begin
                checks++; if (rd_data !== mm[a]) begin errors++; $display("FAIL clean_rd[%0d] got %h exp %h", a, rd_data, mm[a]); end
            end
        end
    endtask

    task automatic test_mid_arm();
        logic [2*W-1:0] b0;
        send_frame(0, 19, -1, -1, 0);
        do_arm();
        send_frame(20, 63, 63, -1, 0);
        send_frame(0, 63, 63, -1, 0);
        b0 = frame_data[0];
        for (int f = 1; f < NF; f++) send_frame(0, 63, 63, -1, 0);
        checks++; if (full !== 1'b1 || frame_count !== 3'd4) begin
            errors++; $display("FAIL mid_full got full=%b fc=%0d exp 1 4", full, frame_count); end
        rd_addr = '0; tick();
        checks++; if (rd_data !== b0) begin errors++; $display("FAIL mid_rd0 got %h exp %h", rd_data, b0); end
        for (int a = 0; a < DEPTH; a += 7) begin
            rd_addr = AW'(a); tick();
            checks++; if (rd_data !== mm[a]) begin errors++; $display("FAIL mid_rd[%0d] got %h exp %h", a, rd_data, mm[a]); end
        end
    endtask

    task automatic test_early_tlast();
        logic [2*W-1:0] f1b0;
        do_arm();
        send_frame(0, 63, 63, -1, 0);
        send_frame(0, 40, 40, 40, 99);
        send_frame(0, 63, 63, -1, 0);
        f1b0 = frame_data[0];
        send_frame(0, 63, 63, -1, 0);
        send_frame(0, 63, 63, -1, 0);
        checks++; if (err_tlast_early !== 1'b1) begin errors++; $display("FAIL early_flag got %b exp 1", err_tlast_early); end
        checks++; if (err_tuser !== 1'b1) begin errors++; $display("FAIL early_tuser got %b exp 1", err_tuser); end
        checks++; if (err_tlast_missing !== 1'b0) begin errors++; $display("FAIL early_miss got %b exp 0", err_tlast_missing); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL early_full got %b exp 1", full); end
        rd_addr = AW'(64); tick();
        checks++; if (rd_data !== f1b0) begin errors++; $display("FAIL early_rd64 got %h exp %h", rd_data, f1b0); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a); tick();
            checks++; if (rd_data !== mm[a]) begin errors++; $display("FAIL early_rd[%0d] got %h exp %h", a, rd_data, mm[a]); end
        end
    endtask

    task automatic test_missing_tuser();
        do_arm();
        checks++; if ({err_tlast_early, err_tuser} !== 2'b00) begin
            errors++; $display("FAIL miss_arm_clear got %b exp 00", {err_tlast_early, err_tuser}); end
        send_frame(0, 63, 63, -1, 0);
        send_frame(0, 63, -1, 4, 5);
        checks++; if (frame_count !== 3'd1) begin errors++; $display("FAIL miss_fcnt got %0d exp 1", frame_count); end
        for (int f = 1; f < NF; f++) send_frame(0, 63, 63, -1, 0);
        checks++; if (err_tlast_missing !== 1'b1) begin errors++; $display("FAIL miss_flag got %b exp 1", err_tlast_missing); end
        checks++; if (err_tuser !== 1'b1) begin errors++; $display("FAIL miss_tuser got %b exp 1", err_tuser); end
        checks++; if (err_tlast_early !== 1'b0) begin errors++; $display("FAIL miss_early got %b exp 0", err_tlast_early); end
        checks++; if (full !== 1'b1 || frame_count !== 3'd4) begin
            errors++; $display("FAIL miss_full got full=%b fc=%0d exp 1 4", full, frame_count); end
        for (int a = 0; a < DEPTH; a += 3) begin
            rd_addr = AW'(a); tick();
            checks++; if (rd_data !== mm[a]) begin errors++; $display("FAIL miss_rd[%0d] got %h exp %h", a, rd_data, mm[a]); end
        end
    endtask

    task automatic test_backpressure();
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            s_axis_tdata = $urandom; s_axis_tuser = TW'(c); s_axis_tlast = c[0];
            checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready[%0d] got %b exp 0", c, s_axis_tready); end
            tick();
        end
        s_axis_tvalid = 1'b0;
        checks++; if (full !== 1'b1 || frame_count !== 3'd4 || busy !== 1'b0 || err_tlast_missing !== 1'b1) begin
            errors++; $display("FAIL bp_hold got full=%b fc=%0d busy=%b miss=%b exp 1 4 0 1", full, frame_count, busy, err_tlast_missing); end
        do_arm();
        checks++; if (full !== 1'b0 || busy !== 1'b1 || frame_count !== '0) begin
            errors++; $display("FAIL bp_rearm got full=%b busy=%b fc=%0d exp 0 1 0", full, busy, frame_count); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_tuser} !== 3'b000) begin
            errors++; $display("FAIL bp_rearm_errs got %b exp 000", {err_tlast_early, err_tlast_missing, err_tuser}); end
        send_frame(0, 63, 63, -1, 0);
        for (int f = 0; f < NF; f++) send_frame(0, 63, 63, -1, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp_full got %b exp 1", full); end
    endtask

    task automatic test_reset_mid();
        do_arm();
        send_frame(0, 63, 63, -1, 0);
        send_frame(0, 63, 63, -1, 0);
        send_frame(0, 63, 63, -1, 0);
        send_frame(0, 29, -1, -1, 0);
        aresetn = 1'b0; model_reset();
        #2;
        checks++; if (s_axis_tready !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || frame_count !== '0) begin
            errors++; $display("FAIL rst_mid got tready=%b full=%b busy=%b fc=%0d exp 1 0 0 0", s_axis_tready, full, busy, frame_count); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_tuser} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_errs got %b exp 000", {err_tlast_early, err_tlast_missing, err_tuser}); end
        tick(); aresetn = 1'b1; tick();
        send_frame(0, 63, 63, -1, 0);
        checks++; if (busy !== 1'b0 || frame_count !== '0) begin
            errors++; $display("FAIL rst_idle got busy=%b fc=%0d exp 0 0", busy, frame_count); end
        do_arm();
        send_frame(0, 63, 63, -1, 0);
        for (int f = 0; f < NF; f++) send_frame(0, 63, 63, -1, 0);
        checks++; if (full !== 1'b1 || frame_count !== 3'd4) begin
            errors++; $display("FAIL rst_recap got full=%b fc=%0d exp 1 4", full, frame_count); end
        checks++; if ({err_tlast_early, err_tlast_missing, err_tuser} !== 3'b000) begin
            errors++; $display("FAIL rst_recap_errs got %b exp 000", {err_tlast_early, err_tlast_missing, err_tuser}); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a); tick();
            checks++; if (rd_data !== mm[a]) begin errors++; $display("FAIL rst_rd[%0d] got %h exp %h", a, rd_data, mm[a]); end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mk[a] = 1'b0;
        model_reset();
        test_reset();
        test_clean();
        test_mid_arm();
        test_early_tlast();
        test_missing_tuser();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_capture.md
FFT_FRAME_CAPTURE -- requirements
Module: fft_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per real/imag component; tdata is 2*WIDTH wide as {im, re}.
REQ-002 SHALL have parameter FFT_LEN, default 64, meaning samples per FFT frame, a power of two of at least 2.
REQ-003 SHALL have parameter NFRAMES, default 4, meaning the number of frames captured per arm.
REQ-004 SHALL have parameter TUSER_WID, default 8, meaning the width of the FFT output XK_INDEX field.
REQ-005 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-006 SHALL have port aresetn, input, 1 bit, the asynchronous active-low reset.
REQ-007 SHALL have port s_axis_tdata, input, 2*WIDTH bits, the FFT output sample.
REQ-008 SHALL have port s_axis_tvalid, input, 1 bit, sample valid.
REQ-009 SHALL have port s_axis_tready, output, 1 bit, sink ready.
REQ-010 SHALL have port s_axis_tlast, input, 1 bit, the last sample of an FFT frame.
REQ-011 SHALL have port s_axis_tuser, input, TUSER_WID bits, the FFT bin index.
REQ-012 SHALL have port arm, input, 1 bit, a single-cycle capture start pulse.
REQ-013 SHALL have port rd_addr, input, AW=$clog2(FFT_LEN*NFRAMES) bits, the readout address.
REQ-014 SHALL have port rd_data, output, 2*WIDTH bits, the readout data.
REQ-015 SHALL have port full, output, 1 bit, asserted when the capture buffer is complete.
REQ-016 SHALL have port busy, output, 1 bit, asserted while in SYNC or CAPTURE.
REQ-017 SHALL have port frame_count, output, $clog2(NFRAMES+1) bits, the number of frames captured.
REQ-018 SHALL have ports err_tlast_early, err_tlast_missing and err_tuser, each output, 1 bit, sticky error flags.

Function
REQ-019 SHALL implement the states IDLE, SYNC, CAPTURE and DONE.
REQ-020 SHALL assert s_axis_tready in IDLE, SYNC and CAPTURE, discarding beats accepted in IDLE and SYNC, and SHALL deassert it in DONE to apply backpressure.
REQ-021 SHALL move IDLE->SYNC or DONE->SYNC on arm, clearing frame_count, full, all error flags and the sample index.
REQ-022 SHALL ignore arm while in SYNC or CAPTURE.
REQ-023 SHALL move SYNC->CAPTURE on an accepted beat with tlast=1, so that capture starts on a frame boundary; that beat SHALL NOT be stored.
REQ-024 SHALL, in CAPTURE, write each accepted beat to mem[frame*FFT_LEN + idx] and then increment idx.
REQ-025 SHALL set err_tuser on a stored beat whose tuser differs from idx truncated to TUSER_WID, and the beat SHALL still be stored.
REQ-026 SHALL close the frame when tlast=1 at idx<FFT_LEN-1, setting err_tlast_early; unwritten slots of that frame SHALL keep their stale contents.
REQ-027 SHALL close the frame when idx=FFT_LEN-1 with tlast=0, setting err_tlast_missing; the next beat SHALL start the next frame.
REQ-028 SHALL, on frame close, reset idx to 0 and increment frame_count.
REQ-029 SHALL, when frame_count reaches NFRAMES, enter DONE and assert full in the cycle after the final write.
REQ-030 SHALL, when an early-tlast and a tuser error occur on the same beat, set both flags.
REQ-031 SHALL provide rd_data = mem[rd_addr] registered with 1-cycle latency, valid in every state; reads concurrent with a write to the same address SHALL return the old data.
REQ-032 SHALL treat rd_addr >= FFT_LEN*NFRAMES as undefined, with no wrap guaranteed.

Reset
REQ-033 SHALL, while aresetn=0, force state IDLE, s_axis_tready=1, full=0, busy=0, frame_count=0, all error flags 0 and idx=0.
REQ-034 SHALL NOT reset the memory contents, and rd_data SHALL be undefined until the first read after reset.
REQ-035 SHALL, on reset asserted mid-CAPTURE, abandon the capture, and capture SHALL restart only after a new arm.

Structure
REQ-036 SHALL place the state enum typedef cap_state_t and the index/address width functions in the shared ospfb package.
REQ-037 SHALL use one sub-module, sdp_ram (simple dual-port, one write and one registered read port, no reset), for storage.

Verification
REQ-038 SHALL cover a clean capture: FFT_LEN=64, NFRAMES=4, arm followed by frames with correct tuser 0..63 and tlast at 63 -> full=1 after 256 stored beats, frame_count=4, no errors, rd_addr=70 returns the frame-1 bin-6 sample.
REQ-039 SHALL cover mid-frame arm: arm at bin 20 -> beats 20..63 discarded, storage starts at the next bin 0, and mem[0] holds bin 0.
REQ-040 SHALL cover early tlast: tlast at bin 40 in frame 0 -> err_tlast_early=1, and frame 1 starts at address 64.
REQ-041 SHALL cover a missing tlast and bad tuser: frame without tlast at bin 63 plus tuser=5 at idx 4 -> err_tlast_missing=1, err_tuser=1, capture continues to full.
REQ-042 SHALL cover backpressure and re-arm: in DONE, tready=0 with tvalid held high for 10 cycles -> no state change; a new arm clears the flags and restarts at SYNC.
REQ-043 SHALL cover reset mid-capture: aresetn low after frame 2 -> all outputs at reset values, and a subsequent arm performs a normal capture.
